// File: rtl/wb_dbg_pkg.sv
// Shared definitions for the Wishbone debug split: FSM encoding, debug register
// offsets (relative to N_DBG) and default parameter values.
package wb_dbg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DBG_ACK  = 2'd1,
        ST_USR_WAIT = 2'd2
    } state_e;

    // Register index = N_DBG - OFS_*; everything below TO_ADDR is scratch.
    localparam int OFS_TO_ADDR  = 3;
    localparam int OFS_TO_COUNT = 2;
    localparam int OFS_STATUS   = 1;

    localparam logic [31:0] DBG_BASE_DEF = 32'h300F_FFF0;
    localparam logic [31:0] TO_DATA_DEF  = 32'hDEAD_BEEF;
    localparam logic [15:0] CNT_MAX      = 16'hFFFF;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_dbg_regfile.sv
// Debug register bank: byte-enabled scratch words, timeout address/count log and
// a sticky W1C timeout flag. A timeout event always wins over a same-cycle clear.
module wb_dbg_regfile
    import wb_dbg_pkg::*;
#(
    parameter int N_DBG = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wr_en,
    input  logic [$clog2(N_DBG)-1:0] i_wr_idx,
    input  logic [3:0]               i_wr_sel,
    input  logic [31:0]              i_wr_data,
    input  logic                     i_to_evt,
    input  logic [31:0]              i_to_addr,
    output logic [N_DBG*32-1:0]      o_regs,
    output logic                     o_flag
);
    localparam int IDX_W = $clog2(N_DBG);
    localparam int N_SCR = N_DBG - 3;

    logic [N_SCR-1:0][31:0] r_scratch;
    logic [31:0]            r_to_addr;
    logic [15:0]            r_to_count;
    logic                   r_flag;
    logic                   w_clr;
    logic [N_DBG-1:0][31:0] w_regs;

    assign w_clr = i_wr_en && (i_wr_idx == IDX_W'(N_DBG - OFS_STATUS))
                   && i_wr_sel[0] && i_wr_data[0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_scratch  <= '0;
            r_to_addr  <= '0;
            r_to_count <= '0;
            r_flag     <= 1'b0;
        end else begin
            for (int k = 0; k < N_SCR; k++) begin
                if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (i_wr_sel[b]) r_scratch[k][8*b +: 8] <= i_wr_data[8*b +: 8];
                    end
                end
            end
            if (i_to_evt) begin
                r_to_addr <= i_to_addr;
                if (r_to_count != CNT_MAX) r_to_count <= r_to_count + 16'd1;
                r_flag <= 1'b1;
            end else if (w_clr) begin
                r_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        w_regs = '0;
        for (int k = 0; k < N_SCR; k++) w_regs[k] = r_scratch[k];
        w_regs[N_DBG - OFS_TO_ADDR]  = r_to_addr;
        w_regs[N_DBG - OFS_TO_COUNT] = {16'h0, r_to_count};
        w_regs[N_DBG - OFS_STATUS]   = {31'h0, r_flag};
    end

    assign o_regs = w_regs;
    assign o_flag = r_flag;

endmodule

// File: rtl/wb_debug_split_regs.sv
// Wishbone split: top N_DBG words go to the local debug bank, everything else to
// the user slave, guarded by an ack watchdog that aborts with TO_DATA and logs.
module wb_debug_split_regs
    import wb_dbg_pkg::*;
#(
    parameter int          N_DBG    = 4,
    parameter logic [31:0] DBG_BASE = DBG_BASE_DEF,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] TO_DATA  = TO_DATA_DEF
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic                usr_cyc_o,
    output logic                usr_stb_o,
    input  logic                usr_ack_i,
    input  logic [31:0]         usr_dat_i,
    output logic [N_DBG*32-1:0] dbg_regs_o,
    output logic                timeout_irq_o
);
    localparam int IDX_W = $clog2(N_DBG);

    state_e             r_state, w_next;
    wb_req_t            r_req;
    logic [IDX_W-1:0]   r_idx;
    logic [31:0]        r_rdata;
    logic [15:0]        r_cnt;
    logic               w_req, w_hit, w_cnt_hit, w_to_evt, w_wr_en;
    logic [IDX_W-1:0]   w_idx;
    logic [N_DBG*32-1:0] w_regs;

    assign w_req     = wbs_cyc_i & wbs_stb_i;
    assign w_hit     = wbs_adr_i[31:IDX_W+2] == DBG_BASE[31:IDX_W+2];
    assign w_idx     = wbs_adr_i[IDX_W+1:2];
    assign w_cnt_hit = r_cnt == 16'(TIMEOUT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_req   <= '0;
            r_idx   <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE) begin
                r_cnt <= '0;
                // Debug reads are served from a snapshot taken as the request is accepted.
                if (w_req) begin
                    r_req   <= '{we: wbs_we_i, sel: wbs_sel_i, dat: wbs_dat_i};
                    r_idx   <= w_idx;
                    r_rdata <= w_regs[{w_idx, 5'd0} +: 32];
                end
            end else if (r_state == ST_USR_WAIT) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        wbs_ack_o = 1'b0;
        wbs_dat_o = '0;
        usr_cyc_o = 1'b0;
        usr_stb_o = 1'b0;
        w_to_evt  = 1'b0;
        w_wr_en   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) w_next = w_hit ? ST_DBG_ACK : ST_USR_WAIT;
            end
            ST_DBG_ACK: begin
                wbs_ack_o = 1'b1;
                wbs_dat_o = r_rdata;
                w_wr_en   = r_req.we;
                w_next    = ST_IDLE;
            end
            ST_USR_WAIT: begin
                if (!wbs_cyc_i) begin
                    w_next = ST_IDLE;
                end else if (usr_ack_i) begin
                    usr_cyc_o = 1'b1;
                    usr_stb_o = wbs_stb_i;
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = usr_dat_i;
                    w_next    = ST_IDLE;
                end else if (w_cnt_hit) begin
                    wbs_ack_o = 1'b1;
                    wbs_dat_o = TO_DATA;
                    w_to_evt  = 1'b1;
                    w_next    = ST_IDLE;
                end else begin
                    usr_cyc_o = 1'b1;
                    usr_stb_o = wbs_stb_i;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    wb_dbg_regfile #(.N_DBG(N_DBG)) u_regs (
        .i_clk     (wb_clk_i),
        .i_rst     (wb_rst_i),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_idx),
        .i_wr_sel  (r_req.sel),
        .i_wr_data (r_req.dat),
        .i_to_evt  (w_to_evt),
        .i_to_addr (wbs_adr_i),
        .o_regs    (w_regs),
        .o_flag    (timeout_irq_o)
    );

    assign dbg_regs_o = w_regs;

endmodule

// File: tb/tb_wb_debug_split_regs.sv
// Directed bench for wb_debug_split_regs plus a direct regfile instance for the
// collision and 16-bit saturation corners.
module tb_wb_debug_split_regs;
    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i;
    logic         wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]   wbs_sel_i;
    logic [31:0]  wbs_adr_i, wbs_dat_i;
    logic         wbs_ack_o;
    logic [31:0]  wbs_dat_o;
    logic         usr_cyc_o, usr_stb_o, usr_ack_i;
    logic [31:0]  usr_dat_i;
    logic [127:0] dbg_regs_o;
    logic         timeout_irq_o;

    logic         rf_wr_en, rf_to_evt, rf_flag;
    logic [1:0]   rf_idx;
    logic [3:0]   rf_sel;
    logic [31:0]  rf_data, rf_to_addr;
    logic [127:0] rf_regs;

    int errs = 0;
    int checks = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    wb_debug_split_regs dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
        .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
        .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
        .usr_cyc_o(usr_cyc_o), .usr_stb_o(usr_stb_o),
        .usr_ack_i(usr_ack_i), .usr_dat_i(usr_dat_i),
        .dbg_regs_o(dbg_regs_o), .timeout_irq_o(timeout_irq_o)
    );

    wb_dbg_regfile #(.N_DBG(4)) u_rf (
        .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_wr_en(rf_wr_en), .i_wr_idx(rf_idx),
        .i_wr_sel(rf_sel), .i_wr_data(rf_data), .i_to_evt(rf_to_evt),
        .i_to_addr(rf_to_addr), .o_regs(rf_regs), .o_flag(rf_flag)
    );

    // One Wishbone access; starts just after a posedge. usr_ack_i is raised in
    // bench cycle ack_at (0 = never). Cycle 1 is the cycle stb is first seen.
    task automatic wb_xfer(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] wdat, input int ack_at, input logic [31:0] udat,
                           output int lat, output logic [31:0] rdat,
                           output logic ustb_at_ack, output logic ucyc_any);
        wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = wdat;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        lat = 0; rdat = 32'h0; ustb_at_ack = 1'b0; ucyc_any = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            usr_ack_i = (c == ack_at);
            usr_dat_i = (c == ack_at) ? udat : 32'h0;
            @(negedge wb_clk_i);
            ucyc_any = ucyc_any | usr_cyc_o;
            if (wbs_ack_o) begin
                lat = c; rdat = wbs_dat_o; ustb_at_ack = usr_stb_o;
                break;
            end
            @(posedge wb_clk_i); #1;
        end
        @(posedge wb_clk_i); #1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        usr_ack_i = 1'b0; usr_dat_i = 32'h0;
    endtask

    task automatic test_reset;
        wb_rst_i = 1'b1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0;
        wbs_adr_i = 0; wbs_dat_i = 0; usr_ack_i = 0; usr_dat_i = 0;
        rf_wr_en = 0; rf_to_evt = 0; rf_idx = 0; rf_sel = 0; rf_data = 0; rf_to_addr = 0;
        repeat (3) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        checks++; if (wbs_ack_o !== 1'b0) begin errs++; $display("FAIL reset_ack got=%b exp=0", wbs_ack_o); end
        checks++; if (wbs_dat_o !== 32'h0) begin errs++; $display("FAIL reset_dat got=%h exp=0", wbs_dat_o); end
        checks++; if ({usr_cyc_o, usr_stb_o} !== 2'b00) begin errs++; $display("FAIL reset_usr got=%b exp=00", {usr_cyc_o, usr_stb_o}); end
        checks++; if (timeout_irq_o !== 1'b0) begin errs++; $display("FAIL reset_irq got=%b exp=0", timeout_irq_o); end
        checks++; if (dbg_regs_o !== 128'h0) begin errs++; $display("FAIL reset_regs got=%h exp=0", dbg_regs_o); end
    endtask

    task automatic test_dbg_rw;
        int lat; logic [31:0] rd; logic us, uc;
        wb_xfer(32'h300F_FFF0, 1'b1, 4'b0011, 32'h1234_5678, 0, 32'h0, lat, rd, us, uc);
        checks++; if (lat !== 2) begin errs++; $display("FAIL dbg_wr_lat got=%0d exp=2", lat); end
        checks++; if (uc !== 1'b0) begin errs++; $display("FAIL dbg_wr_usr_cyc got=%b exp=0", uc); end
        wb_xfer(32'h300F_FFF0, 1'b0, 4'b1111, 32'h0, 0, 32'h0, lat, rd, us, uc);
        checks++; if (lat !== 2) begin errs++; $display("FAIL dbg_rd_lat got=%0d exp=2", lat); end
        checks++; if (rd !== 32'h0000_5678) begin errs++; $display("FAIL dbg_rd_dat got=%h exp=00005678", rd); end
        wb_xfer(32'h300F_FFF0, 1'b1, 4'b1100, 32'hAABB_CCDD, 0, 32'h0, lat, rd, us, uc);
        checks++; if (dbg_regs_o[31:0] !== 32'hAABB_5678) begin errs++; $display("FAIL dbg_sel_hi got=%h exp=aabb5678", dbg_regs_o[31:0]); end
    endtask

    task automatic test_usr_read;
        int lat; logic [31:0] rd; logic us, uc;
        wb_xfer(32'h3000_0000, 1'b0, 4'b1111, 32'h0, 4, 32'hCAFE_F00D, lat, rd, us, uc);
        checks++; if (lat !== 4) begin errs++; $display("FAIL usr_lat got=%0d exp=4", lat); end
        checks++; if (rd !== 32'hCAFE_F00D) begin errs++; $display("FAIL usr_dat got=%h exp=cafef00d", rd); end
        checks++; if ({uc, us} !== 2'b11) begin errs++; $display("FAIL usr_strobes got=%b exp=11", {uc, us}); end
        checks++; if (timeout_irq_o !== 1'b0) begin errs++; $display("FAIL usr_irq got=%b exp=0", timeout_irq_o); end
    endtask

    task automatic test_timeout;
        int lat; logic [31:0] rd; logic us, uc;
        wb_xfer(32'h3000_0000, 1'b0, 4'b1111, 32'h0, 0, 32'h0, lat, rd, us, uc);
        checks++; if (lat !== 257) begin errs++; $display("FAIL to_lat got=%0d exp=257", lat); end
        checks++; if (rd !== 32'hDEAD_BEEF) begin errs++; $display("FAIL to_dat got=%h exp=deadbeef", rd); end
        checks++; if (us !== 1'b0) begin errs++; $display("FAIL to_stb_drop got=%b exp=0", us); end
        checks++; if (dbg_regs_o[63:32] !== 32'h3000_0000) begin errs++; $display("FAIL to_addr got=%h exp=30000000", dbg_regs_o[63:32]); end
        checks++; if (dbg_regs_o[95:64] !== 32'h1) begin errs++; $display("FAIL to_count got=%h exp=1", dbg_regs_o[95:64]); end
        checks++; if (timeout_irq_o !== 1'b1) begin errs++; $display("FAIL to_irq got=%b exp=1", timeout_irq_o); end
        wb_xfer(32'h300F_FFFC, 1'b0, 4'b1111, 32'h0, 0, 32'h0, lat, rd, us, uc);
        checks++; if (rd !== 32'h1) begin errs++; $display("FAIL to_status_rd got=%h exp=1", rd); end
    endtask

    task automatic test_w1c;
        int lat; logic [31:0] rd; logic us, uc;
        wb_xfer(32'h300F_FFFC, 1'b1, 4'b0010, 32'h1, 0, 32'h0, lat, rd, us, uc);
        checks++; if (timeout_irq_o !== 1'b1) begin errs++; $display("FAIL w1c_nosel got=%b exp=1", timeout_irq_o); end
        wb_xfer(32'h300F_FFF8, 1'b1, 4'b1111, 32'h55, 0, 32'h0, lat, rd, us, uc);
        checks++; if (lat !== 2 || dbg_regs_o[95:64] !== 32'h1) begin errs++; $display("FAIL ro_write got=%h lat=%0d exp=1 lat=2", dbg_regs_o[95:64], lat); end
        wb_xfer(32'h300F_FFFC, 1'b1, 4'b0001, 32'h1, 0, 32'h0, lat, rd, us, uc);
        checks++; if (timeout_irq_o !== 1'b0) begin errs++; $display("FAIL w1c_clear got=%b exp=0", timeout_irq_o); end
    endtask

    task automatic test_ack_at_expiry;
        int lat; logic [31:0] rd; logic us, uc;
        wb_xfer(32'h3000_0040, 1'b0, 4'b1111, 32'h0, 257, 32'h0BAD_F00D, lat, rd, us, uc);
        checks++; if (lat !== 257 || rd !== 32'h0BAD_F00D) begin errs++; $display("FAIL expiry_race got=%h lat=%0d exp=0badf00d lat=257", rd, lat); end
        checks++; if (dbg_regs_o[95:64] !== 32'h1) begin errs++; $display("FAIL expiry_count got=%h exp=1", dbg_regs_o[95:64]); end
        checks++; if (timeout_irq_o !== 1'b0) begin errs++; $display("FAIL expiry_irq got=%b exp=0", timeout_irq_o); end
    endtask

    task automatic test_reset_mid;
        wbs_adr_i = 32'h3000_0000; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        #1;
        checks++; if (usr_cyc_o !== 1'b1) begin errs++; $display("FAIL mid_wait_cyc got=%b exp=1", usr_cyc_o); end
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        checks++; if ({usr_cyc_o, usr_stb_o, wbs_ack_o} !== 3'b000) begin errs++; $display("FAIL mid_rst_out got=%b exp=000", {usr_cyc_o, usr_stb_o, wbs_ack_o}); end
        checks++; if (dbg_regs_o !== 128'h0) begin errs++; $display("FAIL mid_rst_regs got=%h exp=0", dbg_regs_o); end
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        @(posedge wb_clk_i); #1 wb_rst_i = 1'b0;
    endtask

    task automatic test_rf_collision;
        rf_to_addr = 32'h1234_0000; rf_to_evt = 1'b1;
        @(posedge wb_clk_i); #1;
        checks++; if (rf_flag !== 1'b1) begin errs++; $display("FAIL rf_set got=%b exp=1", rf_flag); end
        rf_wr_en = 1'b1; rf_idx = 2'd3; rf_sel = 4'b0001; rf_data = 32'h1;
        @(posedge wb_clk_i); #1;
        checks++; if (rf_flag !== 1'b1) begin errs++; $display("FAIL rf_w1c_collide got=%b exp=1", rf_flag); end
        rf_to_evt = 1'b0;
        @(posedge wb_clk_i); #1;
        rf_wr_en = 1'b0;
        checks++; if (rf_flag !== 1'b0 || rf_regs[95:64] !== 32'h2) begin errs++; $display("FAIL rf_clear got=%b cnt=%h exp=0 cnt=2", rf_flag, rf_regs[95:64]); end
    endtask

    task automatic test_saturation;
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0; rf_to_evt = 1'b1; rf_to_addr = 32'h3000_0ABC;
        repeat (65534) @(posedge wb_clk_i);
        #1;
        checks++; if (rf_regs[95:64] !== 32'h0000_FFFE) begin errs++; $display("FAIL sat_65534 got=%h exp=0000fffe", rf_regs[95:64]); end
        @(posedge wb_clk_i); #1;
        checks++; if (rf_regs[95:64] !== 32'h0000_FFFF) begin errs++; $display("FAIL sat_65535 got=%h exp=0000ffff", rf_regs[95:64]); end
        @(posedge wb_clk_i); #1;
        rf_to_evt = 1'b0;
        checks++; if (rf_regs[95:64] !== 32'h0000_FFFF) begin errs++; $display("FAIL sat_65536 got=%h exp=0000ffff", rf_regs[95:64]); end
        checks++; if (rf_regs[63:32] !== 32'h3000_0ABC) begin errs++; $display("FAIL sat_addr got=%h exp=30000abc", rf_regs[63:32]); end
    endtask

    initial begin
        test_reset;
        test_dbg_rw;
        test_usr_read;
        test_timeout;
        test_w1c;
        test_ack_at_expiry;
        test_reset_mid;
        test_rf_collision;
        test_saturation;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
